// File: rtl/mem_access_pkg.sv
// Shared types and widths for the MIPS memory-access stage.
package mem_access_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/dm_handshake_fsm.sv
// req/gnt/rvalid handshake controller: state, kill flag and the dm_req/Stall decode.
import mem_access_pkg::*;

module dm_handshake_fsm (
  input  logic   clk,
  input  logic   rst,
  input  logic   mem_op,
  input  logic   misalign,
  input  logic   flush,
  input  logic   stall_in,
  input  logic   dm_gnt,
  input  logic   dm_rvalid,
  output state_e state,
  output logic   kill,
  output logic   dm_req,
  output logic   stall,
  output logic   rsp_take
);
  logic issue;

  assign issue    = mem_op && !flush && !misalign;
  assign rsp_take = (state == ST_WAIT) && dm_rvalid;

  // Decode is gated by reset so dm_req drops the moment reset asserts.
  always_comb begin
    dm_req = 1'b0;
    stall  = 1'b0;
    case (state)
      ST_IDLE: begin dm_req = issue; stall = issue; end
      ST_REQ:  begin dm_req = 1'b1;  stall = 1'b1;  end
      ST_WAIT: stall = 1'b1;
      default: ;
    endcase
    dm_req = rst && dm_req;
    stall  = rst && stall;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      kill  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (issue) state <= dm_gnt ? ST_WAIT : ST_REQ;
        // A grant coinciding with flush is still owed a response, so it wins.
        ST_REQ: begin
          if (dm_gnt) begin
            state <= ST_WAIT;
            if (flush) kill <= 1'b1;
          end else if (flush) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (flush)     kill  <= 1'b1;
          if (dm_rvalid) state <= ST_DONE;
        end
        ST_DONE: if (!stall_in) begin
          state <= ST_IDLE;
          kill  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage: data path around dm_handshake_fsm.
// Optional alignment check enabled by defining MEM_ACCESS_ALIGN_CHK_EN.
import mem_access_pkg::*;

module mem_access #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush,
  input  logic [DATA_W-1:0] EXM_ALU_Result,
  input  logic [DATA_W-1:0] EXM_WrData,
  input  logic [TAG_W-1:0]  EXM_Rs,
  input  logic [TAG_W-1:0]  EXM_Rt,
  input  logic [TAG_W-1:0]  EXM_Rdst,
  input  logic              EXM_RegW,
  input  logic              EXM_MemR,
  input  logic              EXM_MemW,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] MEM_ALU_Result,
  output logic [TAG_W-1:0]  MEM_Rs,
  output logic [TAG_W-1:0]  MEM_Rt,
  output logic [TAG_W-1:0]  MEM_Rdst,
  output logic              MEM_RegW,
  output logic              MEM_MemR,
  output logic              MEM_MemW,
  output logic              Stall,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_e            state;
  logic              kill, rsp_take, mem_op, misalign, kill_out;
  logic [DATA_W-1:0] load_q;

  assign mem_op = EXM_MemR || EXM_MemW;

`ifdef MEM_ACCESS_ALIGN_CHK_EN
  assign misalign = rst && (state == ST_IDLE) && mem_op && !flush &&
                    (EXM_ALU_Result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  dm_handshake_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_op   (mem_op),
    .misalign (misalign),
    .flush    (flush),
    .stall_in (stall_in),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .state    (state),
    .kill     (kill),
    .dm_req   (dm_req),
    .stall    (Stall),
    .rsp_take (rsp_take)
  );

  // Request fields come straight from the EX/MEM register, which Stall holds.
  assign dm_we        = EXM_MemW;
  assign dm_addr      = {EXM_ALU_Result[DATA_W-1:2], 2'b00};
  assign dm_wdata     = EXM_WrData;
  assign misalign_err = misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       load_q <= '0;
    else if (rsp_take && EXM_MemR)  load_q <= dm_rdata;
  end

  assign kill_out       = misalign || ((state == ST_DONE) && (kill || flush));
  assign MEM_ALU_Result = ((state == ST_DONE) && EXM_MemR) ? load_q : EXM_ALU_Result;
  assign MEM_Rs         = EXM_Rs;
  assign MEM_Rt         = EXM_Rt;
  assign MEM_Rdst       = EXM_Rdst;
  assign MEM_RegW       = EXM_RegW && !kill_out;
  assign MEM_MemR       = EXM_MemR && !kill_out;
  assign MEM_MemW       = EXM_MemW && !kill_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           stall_cnt <= '0;
    else if (Stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected writeback values queued at issue,
// popped when the stage releases the instruction to MEM_WB.
module tb_mem_access;
  logic        clk = 1'b0, rst = 1'b0;
  logic        stall_in = 1'b0, flush = 1'b0;
  logic [31:0] EXM_ALU_Result = '0, EXM_WrData = '0;
  logic [4:0]  EXM_Rs = '0, EXM_Rt = '0, EXM_Rdst = '0;
  logic        EXM_RegW = 1'b0, EXM_MemR = 1'b0, EXM_MemW = 1'b0;
  logic        dm_req, dm_we, dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = '0;
  logic [31:0] MEM_ALU_Result;
  logic [4:0]  MEM_Rs, MEM_Rt, MEM_Rdst;
  logic        MEM_RegW, MEM_MemR, MEM_MemW, Stall, misalign_err;
  logic [3:0]  stall_cnt;

  mem_access #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .EXM_ALU_Result(EXM_ALU_Result), .EXM_WrData(EXM_WrData),
    .EXM_Rs(EXM_Rs), .EXM_Rt(EXM_Rt), .EXM_Rdst(EXM_Rdst),
    .EXM_RegW(EXM_RegW), .EXM_MemR(EXM_MemR), .EXM_MemW(EXM_MemW),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .MEM_ALU_Result(MEM_ALU_Result), .MEM_Rs(MEM_Rs), .MEM_Rt(MEM_Rt),
    .MEM_Rdst(MEM_Rdst), .MEM_RegW(MEM_RegW), .MEM_MemR(MEM_MemR),
    .MEM_MemW(MEM_MemW), .Stall(Stall), .misalign_err(misalign_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, act, exp, $time);
    end
  endtask

  // Memory model: grant after gnt_dly waiting cycles, respond rsp_dly cycles after grant.
  int          gnt_dly = 0, rsp_dly = 1, wait_cnt = 0, rsp_cnt = 0;
  int          grants = 0, req_cycles = 0;
  logic [31:0] rsp_data = '0, exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;

  always @(negedge clk) begin
    dm_rvalid = 1'b0;
    dm_rdata  = 32'hBAD0_BAD0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin dm_rvalid = 1'b1; dm_rdata = rsp_data; end
    end
    dm_gnt = 1'b0;
    if (dm_req) begin
      req_cycles++;
      chk("dm_addr", dm_addr, exp_addr);
      chk("dm_we", {31'b0, dm_we}, {31'b0, exp_we});
      chk("dm_wdata", dm_wdata, exp_wdata);
      if (wait_cnt >= gnt_dly) begin
        dm_gnt = 1'b1; grants++; rsp_cnt = rsp_dly; wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // Scoreboard: compare when the stage releases to MEM_WB (Stall=0, no stall_in).
  typedef struct { logic [31:0] res; logic regw; } exp_t;
  exp_t sb[$];
  logic inst_vld = 1'b0, done = 1'b0, saw_mis = 1'b0;
  int   stall_run = 0, last_stall = 0;

  always @(negedge clk) begin
    if (misalign_err) saw_mis = 1'b1;
    if (inst_vld && rst) begin
      if (Stall) stall_run++;
      else if (!stall_in) begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("mem_result", MEM_ALU_Result, e.res);
          chk("mem_regw", {31'b0, MEM_RegW}, {31'b0, e.regw});
        end
        last_stall = stall_run; stall_run = 0; done = 1'b1;
      end
    end
  end

  task automatic nop();
    EXM_ALU_Result = '0; EXM_WrData = '0; EXM_RegW = 1'b0;
    EXM_MemR = 1'b0; EXM_MemW = 1'b0; flush = 1'b0; stall_in = 1'b0;
  endtask

  // Called at posedge+1; fc = flush cycle, si0..si1 = stall_in cycles (relative).
  task automatic issue(input logic r, w, regw, input logic [31:0] alu, wd, rd,
                       input int gd, rdly, fc, si0, si1,
                       input logic [31:0] exp_res, input logic exp_regw);
    exp_t e;
    int   cyc;
    exp_addr = alu & 32'hFFFF_FFFC; exp_we = w; exp_wdata = wd;
    gnt_dly = gd; rsp_dly = rdly; rsp_data = rd;
    e.res = exp_res; e.regw = exp_regw;
    sb.push_back(e);
    EXM_MemR = r; EXM_MemW = w; EXM_RegW = regw; EXM_ALU_Result = alu; EXM_WrData = wd;
    EXM_Rdst = 5'd7;
    done = 1'b0; stall_run = 0; inst_vld = 1'b1; cyc = 0;
    while (!done && cyc < 60) begin
      flush    = (cyc == fc);
      stall_in = (cyc >= si0) && (cyc <= si1);
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    inst_vld = 1'b0;
    nop();
  endtask

  int g0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, dm_req}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    chk("rst_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("rst_res", MEM_ALU_Result, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through
    g0 = grants; r0 = req_cycles;
    issue(0, 0, 1, 32'h1234, 0, 0, 0, 1, -1, -1, -1, 32'h1234, 1);
    chk("alu_stall", last_stall, 0);
    chk("alu_req", req_cycles - r0, 0);

    // load, grant at once, response 3 cycles later
    g0 = grants;
    issue(1, 0, 1, 32'h40, 0, 32'hDEAD_BEEF, 0, 3, -1, -1, -1, 32'hDEAD_BEEF, 1);
    chk("ld_stall", last_stall, 4);
    chk("ld_cnt", {28'b0, stall_cnt}, 32'd4);
    chk("ld_grants", grants - g0, 1);

    // reset during WAIT, stale response after release
    exp_addr = 32'h400; exp_we = 1'b0; exp_wdata = '0;
    gnt_dly = 0; rsp_dly = 4; rsp_data = 32'h1111_1111;
    EXM_MemR = 1'b1; EXM_RegW = 1'b1; EXM_ALU_Result = 32'h400;
    @(posedge clk); #1;
    chk("pre_rst_stall", {31'b0, Stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, dm_req}, 32'd0);
    chk("rst_async_stall", {31'b0, Stall}, 32'd0);
    nop();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stale_stall", {31'b0, Stall}, 32'd0);
    end
    chk("rst_cnt2", {28'b0, stall_cnt}, 32'd0);
    @(posedge clk); #1;

    // store with grant held off 2 cycles
    g0 = grants; r0 = req_cycles;
    issue(0, 1, 0, 32'h80, 32'hCAFE_F00D, 0, 2, 1, -1, -1, -1, 32'h80, 0);
    chk("st_req_cycles", req_cycles - r0, 3);
    chk("st_grants", grants - g0, 1);
    chk("st_stall", last_stall, 4);

    // flush in REQ: request withdrawn, no grant
    g0 = grants;
    exp_addr = 32'h100; exp_we = 1'b0; exp_wdata = '0; gnt_dly = 10;
    EXM_MemR = 1'b1; EXM_RegW = 1'b1; EXM_ALU_Result = 32'h100;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("req_state_req", {31'b0, dm_req}, 32'd1);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    chk("flush_req_drop", {31'b0, dm_req}, 32'd0);
    chk("flush_req_stall", {31'b0, Stall}, 32'd0);
    chk("flush_req_grants", grants - g0, 0);
    @(posedge clk); #1;

    // flush in WAIT: response consumed, bubble
    issue(1, 0, 1, 32'h200, 0, 32'h1111_2222, 0, 3, 1, -1, -1, 32'h1111_2222, 0);
    chk("fw_stall", last_stall, 4);

    // kill flag must clear for the next load
    issue(1, 0, 1, 32'h300, 0, 32'h5A5A_1234, 0, 1, -1, -1, -1, 32'h5A5A_1234, 1);
    chk("best_stall", last_stall, 2);

    // stall_in holds DONE for two extra cycles
    g0 = grants;
    issue(1, 0, 1, 32'h304, 0, 32'h0BAD_F00D, 0, 1, -1, 2, 3, 32'h0BAD_F00D, 1);
    chk("si_stall", last_stall, 2);
    chk("si_grants", grants - g0, 1);

    // flush in DONE
    issue(1, 0, 1, 32'h308, 0, 32'h2468_ACE0, 0, 1, 2, -1, -1, 32'h2468_ACE0, 0);

    // long store pushes the 4-bit counter into saturation
    issue(0, 1, 0, 32'h500, 32'h1357_9BDF, 0, 3, 2, -1, -1, -1, 32'h500, 0);
    chk("long_stall", last_stall, 6);

`ifdef MEM_ACCESS_ALIGN_CHK_EN
    g0 = grants; r0 = req_cycles;
    exp_addr = 32'h40; exp_we = 1'b0; exp_wdata = '0; gnt_dly = 0; rsp_dly = 1;
    EXM_MemR = 1'b1; EXM_RegW = 1'b1; EXM_ALU_Result = 32'h42;
    @(negedge clk);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_req", {31'b0, dm_req}, 32'd0);
    chk("mis_stall", {31'b0, Stall}, 32'd0);
    chk("mis_regw", {31'b0, MEM_RegW}, 32'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    chk("mis_pulse", {31'b0, misalign_err}, 32'd0);
    chk("mis_grants", grants - g0, 0);
    @(posedge clk); #1;
`else
    issue(1, 0, 1, 32'h42, 0, 32'h0000_0077, 0, 1, -1, -1, -1, 32'h0000_0077, 1);
    chk("nochk_mis", {31'b0, saw_mis}, 32'd0);
`endif

    chk("cnt_sat", {28'b0, stall_cnt}, 32'd15);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
